// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: registered N-to-1 channel multiplexer with direct and
// auto-scan selection.
//
// Ports:
//   CLK        clock; all state updates on its rising edge
//   RESET      synchronous active-high reset
//   IN         packed channels, channel k = IN[k*WIDTH +: WIDTH]
//   SEL        direct-mode channel index
//   SEL_VALID  SEL is meaningful this cycle
//   MODE       0 = direct select, 1 = auto-scan
//   EN         when low, all state holds and OUT_VALID drops
//   OUT        registered selected data (one cycle latency)
//   OUT_VALID  OUT was captured on the previous edge
//   CUR_SEL    index of the channel held in OUT
//   SEL_ERR    the last direct-mode request had SEL >= N_IN
module mux_nx1_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned SW    = $clog2(N_IN)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_IN*WIDTH-1:0] IN,
  input  logic [SW-1:0]         SEL,
  input  logic                  SEL_VALID,
  input  logic                  MODE,
  input  logic                  EN,
  output logic [WIDTH-1:0]      OUT,
  output logic                  OUT_VALID,
  output logic [SW-1:0]         CUR_SEL,
  output logic                  SEL_ERR
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    cur_sel_q, cur_sel_d;
  logic             sel_err_q, sel_err_d;
  logic [SW-1:0]    cnt_q, cnt_d;

  logic [SW-1:0]    idx;
  logic [WIDTH-1:0] chan;
  logic             sel_in_range;
  logic             cnt_last;

  // One shared channel mux: the scan counter drives it in scan mode,
  // SEL in direct mode.
  assign idx = MODE ? cnt_q : SEL;

  always_comb begin
    chan = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (idx == SW'(k)) chan = IN[k*WIDTH +: WIDTH];
    end
  end

  assign sel_in_range = (32'(SEL) < N_IN);
  // Wrap at N_IN-1 rather than at 2^SW-1.
  assign cnt_last     = (cnt_q == SW'(N_IN - 1));

  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    cur_sel_d   = cur_sel_q;
    sel_err_d   = sel_err_q;
    cnt_d       = cnt_q;

    // Direct mode always parks the counter at 0 (even with EN low) so the
    // next entry into scan mode starts at channel 0.
    if (!MODE) cnt_d = '0;

    if (EN) begin
      if (MODE) begin
        out_d       = chan;
        cur_sel_d   = cnt_q;
        out_valid_d = 1'b1;
        sel_err_d   = 1'b0;
        cnt_d       = cnt_last ? '0 : cnt_q + 1'b1;
      end else if (SEL_VALID) begin
        if (sel_in_range) begin
          out_d       = chan;
          cur_sel_d   = SEL;
          out_valid_d = 1'b1;
          sel_err_d   = 1'b0;
        end else begin
          sel_err_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cur_sel_q   <= '0;
      sel_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cur_sel_q   <= cur_sel_d;
      sel_err_q   <= sel_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign CUR_SEL   = cur_sel_q;
  assign SEL_ERR   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Testbench for mux_nx1_pipe: two instances (N_IN=4 and N_IN=3, WIDTH=8)
// driven by directed vectors; expected outputs are queued per edge and
// compared by an independent monitor process.
module tb_mux_nx1_pipe;

  localparam int unsigned W = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance A: N_IN = 4
  logic         a_rst, a_sv, a_mode, a_en;
  logic [4*W-1:0] a_in;
  logic [1:0]   a_sel;
  logic [W-1:0] a_out;
  logic         a_ov, a_err;
  logic [1:0]   a_cur;

  // Instance B: N_IN = 3
  logic         b_rst, b_sv, b_mode, b_en;
  logic [3*W-1:0] b_in;
  logic [1:0]   b_sel;
  logic [W-1:0] b_out;
  logic         b_ov, b_err;
  logic [1:0]   b_cur;

  mux_nx1_pipe #(.WIDTH(W), .N_IN(4)) dut_a (
    .CLK(CLK), .RESET(a_rst), .IN(a_in), .SEL(a_sel), .SEL_VALID(a_sv),
    .MODE(a_mode), .EN(a_en), .OUT(a_out), .OUT_VALID(a_ov),
    .CUR_SEL(a_cur), .SEL_ERR(a_err)
  );

  mux_nx1_pipe #(.WIDTH(W), .N_IN(3)) dut_b (
    .CLK(CLK), .RESET(b_rst), .IN(b_in), .SEL(b_sel), .SEL_VALID(b_sv),
    .MODE(b_mode), .EN(b_en), .OUT(b_out), .OUT_VALID(b_ov),
    .CUR_SEL(b_cur), .SEL_ERR(b_err)
  );

  typedef struct {
    bit         dut_b;
    logic [W-1:0] out;
    logic       valid;
    logic [1:0] cur;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each edge and checks the entry
  // queued for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.dut_b) begin
          chk({e.tag, ".OUT"},       32'(a_out), 32'(e.out));
          chk({e.tag, ".OUT_VALID"}, 32'(a_ov),  32'(e.valid));
          chk({e.tag, ".CUR_SEL"},   32'(a_cur), 32'(e.cur));
          chk({e.tag, ".SEL_ERR"},   32'(a_err), 32'(e.err));
        end else begin
          chk({e.tag, ".OUT"},       32'(b_out), 32'(e.out));
          chk({e.tag, ".OUT_VALID"}, 32'(b_ov),  32'(e.valid));
          chk({e.tag, ".CUR_SEL"},   32'(b_cur), 32'(e.cur));
          chk({e.tag, ".SEL_ERR"},   32'(b_err), 32'(e.err));
        end
      end
    end
  end

  // Drive one vector at the falling edge, queue its expected result, and
  // let the next rising edge capture it.
  task automatic vec(input bit b, input string tag, input logic rst, input logic en,
                     input logic mode, input logic sv, input logic [1:0] sel,
                     input logic [W-1:0] eo, input logic ev, input logic [1:0] ec,
                     input logic ee);
    exp_t e;
    @(negedge CLK);
    if (!b) begin
      a_rst = rst; a_en = en; a_mode = mode; a_sv = sv; a_sel = sel;
    end else begin
      b_rst = rst; b_en = en; b_mode = mode; b_sv = sv; b_sel = sel;
    end
    e.dut_b = b; e.out = eo; e.valid = ev; e.cur = ec; e.err = ee; e.tag = tag;
    sb.push_back(e);
    @(posedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] scan_out [6];
    logic [1:0]   scan_cur [6];
    scan_out = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2};
    scan_cur = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    a_rst = 1'b1; a_en = 1'b1; a_mode = 1'b1; a_sv = 1'b0; a_sel = '0;
    a_in  = {8'd4, 8'd3, 8'd2, 8'd1};
    b_rst = 1'b1; b_en = 1'b0; b_mode = 1'b0; b_sv = 1'b0; b_sel = '0;
    b_in  = {8'd30, 8'd20, 8'd10};

    // ---- Instance A (N_IN = 4) ----
    // Reset for two cycles, with EN and MODE active
    vec(0, "rst0", 1, 1, 1, 1, 2'd2, 8'd0, 0, 2'd0, 0);
    vec(0, "rst1", 1, 1, 1, 1, 2'd2, 8'd0, 0, 2'd0, 0);
    // Direct select of channel 2, then SEL_VALID low holds
    vec(0, "dir2",  0, 1, 0, 1, 2'd2, 8'd3, 1, 2'd2, 0);
    vec(0, "dirnv", 0, 1, 0, 0, 2'd0, 8'd3, 0, 2'd2, 0);
    // Scan six cycles; SEL/SEL_VALID are driven but must be ignored
    for (int i = 0; i < 6; i++)
      vec(0, $sformatf("scan%0d", i), 0, 1, 1, 1, 2'd3,
          scan_out[i], 1, scan_cur[i], 0);
    // Counter now at 2: freeze for three cycles, then resume at channel 2
    for (int i = 0; i < 3; i++)
      vec(0, $sformatf("frz%0d", i), 0, 0, 1, 1, 2'd0, 8'd2, 0, 2'd1, 0);
    vec(0, "resume", 0, 1, 1, 0, 2'd0, 8'd3, 1, 2'd2, 0);
    // Counter now at 3: reset mid-scan, then restart at channel 0
    vec(0, "rstmid", 1, 1, 1, 0, 2'd0, 8'd0, 0, 2'd0, 0);
    vec(0, "post0",  0, 1, 1, 0, 2'd0, 8'd1, 1, 2'd0, 0);
    vec(0, "post1",  0, 1, 1, 0, 2'd0, 8'd2, 1, 2'd1, 0);
    // Scan -> direct takes effect on the same edge
    vec(0, "todir",  0, 1, 0, 1, 2'd3, 8'd4, 1, 2'd3, 0);
    // Direct -> scan restarts at channel 0
    vec(0, "toscan", 0, 1, 1, 0, 2'd0, 8'd1, 1, 2'd0, 0);
    // Input changes between edges do not reach OUT
    vec(0, "hold",   0, 1, 0, 0, 2'd0, 8'd1, 0, 2'd0, 0);
    @(negedge CLK);
    a_in = {8'd44, 8'd33, 8'd22, 8'd11};
    #2;
    chk("between_edges.OUT", 32'(a_out), 32'(8'd1));
    vec(0, "newin",  0, 1, 0, 1, 2'd1, 8'd22, 1, 2'd1, 0);

    // ---- Instance B (N_IN = 3) ----
    vec(1, "b_rst",  1, 1, 0, 0, 2'd0, 8'd0,  0, 2'd0, 0);
    vec(1, "b_dir1", 0, 1, 0, 1, 2'd1, 8'd20, 1, 2'd1, 0);
    vec(1, "b_oor",  0, 1, 0, 1, 2'd3, 8'd20, 0, 2'd1, 1);
    vec(1, "b_oorh", 0, 1, 0, 0, 2'd0, 8'd20, 0, 2'd1, 1);
    vec(1, "b_dir0", 0, 1, 0, 1, 2'd0, 8'd10, 1, 2'd0, 0);
    // Scan wraps after channel 2, not 3
    vec(1, "b_sc0",  0, 1, 1, 0, 2'd0, 8'd10, 1, 2'd0, 0);
    vec(1, "b_sc1",  0, 1, 1, 0, 2'd0, 8'd20, 1, 2'd1, 0);
    vec(1, "b_sc2",  0, 1, 1, 0, 2'd0, 8'd30, 1, 2'd2, 0);
    vec(1, "b_sc3",  0, 1, 1, 0, 2'd0, 8'd10, 1, 2'd0, 0);

    @(posedge CLK);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
